// File: rtl/lbdr_dr_param.sv
// lbdr_dr_param: minimal 5-port LBDR routing unit with one deroute port and
// per-packet route locking. One instance sits behind each router input FIFO.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   empty, flit_type         FIFO head status / flit type code
//   dst_addr                 destination {y,x} of the head flit (valid on HEADER)
//   pop                      head flit consumed this cycle
//   Rxy/Cx/dr/cur_addr_rst   configuration loaded while in reset
//   cfg_we, *_in             runtime configuration write (honoured in IDLE only)
//   N/E/W/S/Lport            registered one-hot output-port request
//   deroute                  current packet leaves through the deroute port
//   route_err                sticky: a header found no legal port
//   discard                  drain request while an unroutable packet is at head
//   busy                     a packet is in progress
module lbdr_dr_param #(
  parameter int         COORD_W = 2,
  parameter logic [2:0] HEADER  = 3'b001,
  parameter logic [2:0] BODY    = 3'b010,
  parameter logic [2:0] TAIL    = 3'b100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 empty,
  input  logic [2:0]           flit_type,
  input  logic [2*COORD_W-1:0] dst_addr,
  input  logic                 pop,
  input  logic [7:0]           Rxy_rst,
  input  logic [3:0]           Cx_rst,
  input  logic [1:0]           dr_rst,
  input  logic [2*COORD_W-1:0] cur_addr_rst,
  input  logic                 cfg_we,
  input  logic [7:0]           Rxy_in,
  input  logic [3:0]           Cx_in,
  input  logic [1:0]           dr_in,
  input  logic [2*COORD_W-1:0] cur_addr_in,
  output logic                 Nport,
  output logic                 Eport,
  output logic                 Wport,
  output logic                 Sport,
  output logic                 Lport,
  output logic                 deroute,
  output logic                 route_err,
  output logic                 discard,
  output logic                 busy
);

  localparam int AW = 2 * COORD_W;

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

  state_t            state;
  logic [7:0]        rxy;
  logic [3:0]        cx;
  logic [1:0]        dr;
  logic [AW-1:0]     cur_addr;
  // port_q bit order: [0]N [1]E [2]W [3]S [4]L (N..S share the dr/Cx index)
  logic [4:0]        port_q;

  logic [COORD_W-1:0] x_cur, y_cur, x_dst, y_dst;
  logic               n1, s1, e1, w1, local_hit;
  logic [3:0]         req;
  logic [4:0]         route_vec;
  logic               route_dr, route_ok;
  logic               hdr, tail_pop;

  assign x_cur = cur_addr[COORD_W-1:0];
  assign y_cur = cur_addr[AW-1:COORD_W];
  assign x_dst = dst_addr[COORD_W-1:0];
  assign y_dst = dst_addr[AW-1:COORD_W];

  assign n1 = y_dst < y_cur;
  assign s1 = y_cur < y_dst;
  assign e1 = x_cur < x_dst;
  assign w1 = x_dst < x_cur;
  assign local_hit = ~n1 & ~e1 & ~w1 & ~s1;

  assign req[0] = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy[0]) | (n1 & w1 & rxy[1])) & cx[0];
  assign req[1] = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy[2]) | (e1 & s1 & rxy[3])) & cx[1];
  assign req[2] = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy[4]) | (w1 & s1 & rxy[5])) & cx[2];
  assign req[3] = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy[6]) | (s1 & w1 & rxy[7])) & cx[3];

  // Local wins outright (ignores Cx); then N > E > W > S; then deroute
  // through dr only if that port is connected.
  always_comb begin
    route_vec = '0;
    route_dr  = 1'b0;
    if (local_hit)   route_vec[4] = 1'b1;
    else if (req[0]) route_vec[0] = 1'b1;
    else if (req[1]) route_vec[1] = 1'b1;
    else if (req[2]) route_vec[2] = 1'b1;
    else if (req[3]) route_vec[3] = 1'b1;
    else if (cx[dr]) begin
      route_vec[dr] = 1'b1;
      route_dr      = 1'b1;
    end
  end

  assign route_ok = |route_vec;
  assign hdr      = ~empty & (flit_type == HEADER);
  assign tail_pop = pop & ~empty & (flit_type == TAIL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rxy       <= Rxy_rst;
      cx        <= Cx_rst;
      dr        <= dr_rst;
      cur_addr  <= cur_addr_rst;
      state     <= IDLE;
      port_q    <= '0;
      deroute   <= 1'b0;
      route_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A header in the same cycle is routed with the old config
          // (route_vec is computed from the current registers).
          if (cfg_we) begin
            rxy       <= Rxy_in;
            cx        <= Cx_in;
            dr        <= dr_in;
            cur_addr  <= cur_addr_in;
            route_err <= 1'b0;
          end
          if (hdr) begin
            if (route_ok) begin
              port_q  <= route_vec;
              deroute <= route_dr;
              state   <= ACTIVE;
            end else begin
              route_err <= 1'b1;
              state     <= DROP;
            end
          end
        end
        ACTIVE: begin
          // Route is locked until the tail leaves; empty does not clear it.
          if (tail_pop) begin
            port_q  <= '0;
            deroute <= 1'b0;
            state   <= IDLE;
          end
        end
        DROP: begin
          if (tail_pop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Nport   = port_q[0];
  assign Eport   = port_q[1];
  assign Wport   = port_q[2];
  assign Sport   = port_q[3];
  assign Lport   = port_q[4];
  assign busy    = (state != IDLE);
  assign discard = (state == DROP) & ~empty;

endmodule

// File: doc/lbdr_dr_param.md
Name: lbdr_dr_param

Overview:
- Parametrised successor of the minimal LBDR routing unit: full 5-port minimal LBDR (N/E/W/S/L) with configurable coordinate width, one deroute port for unreachable minimal quadrants, and per-packet route locking from HEADER until TAIL.
- One instance per router input port, between the input FIFO (empty/flit_type/dst_addr) and the allocator.
- Routing and connectivity configuration is loaded at reset and can be rewritten at runtime between packets.

Parameters:
COORD_W, 2, bits per coordinate; address width is 2*COORD_W, x in the low half, y in the high half
HEADER, 3'b001, flit_type code for header flit
BODY, 3'b010, flit_type code for body flit
TAIL, 3'b100, flit_type code for tail flit

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
empty  in  1  input FIFO empty
flit_type  in  3  type of flit at FIFO head
dst_addr  in  2*COORD_W  destination address of flit at head (valid on HEADER)
pop  in  1  head flit consumed this cycle (allocator grant or discard)
Rxy_rst  in  8  routing bits at reset: [0]ne [1]nw [2]en [3]es [4]wn [5]ws [6]se [7]sw
Cx_rst  in  4  connectivity at reset: [0]N [1]E [2]W [3]S
dr_rst  in  2  deroute port at reset: 00 N, 01 E, 10 W, 11 S
cur_addr_rst  in  2*COORD_W  router address at reset
cfg_we  in  1  runtime configuration write strobe
Rxy_in, Cx_in, dr_in, cur_addr_in  in  8/4/2/2*COORD_W  runtime configuration values
Nport, Eport, Wport, Sport, Lport  out  1 each  registered one-hot output-port request
deroute  out  1  current packet routed via deroute port
route_err  out  1  sticky: a header had no legal port
discard  out  1  drain request for an unroutable packet
busy  out  1  packet in progress (state != IDLE)

Behaviour:
- Reset (rst==0 at posedge clk): Rxy/Cx/dr/cur_addr load their *_rst values; state IDLE; all port outputs, deroute, route_err, discard, busy = 0.
- Comparators (unsigned): N1 = y_dst<y_cur; S1 = y_cur<y_dst; E1 = x_cur<x_dst; W1 = x_dst<x_cur.
- Minimal port requests:
  - N = ((N1&~E1&~W1)|(N1&E1&Rne)|(N1&W1&Rnw))&Cn
  - E = ((E1&~N1&~S1)|(E1&N1&Ren)|(E1&S1&Res))&Ce
  - W, S: same form using the wn/ws and se/sw bits.
  - L = ~N1&~E1&~W1&~S1.
- Priority if more than one minimal port is set: N > E > W > S. Outputs are always one-hot or zero.
- Deroute: if not local and no minimal port is set, select the port coded by dr. If Cx of that port is 1, assert it and set deroute=1. Otherwise the header has no legal port.
- States: IDLE, ACTIVE, DROP.
- IDLE with ~empty and flit_type==HEADER:
  - Legal port found: port registered at the next edge (1-cycle latency), busy=1, go to ACTIVE.
  - No legal port: ports stay 0, route_err<=1, go to DROP.
- IDLE with a non-HEADER flit at head: ignored; no state change and no outputs.
- ACTIVE:
  - Port and deroute are held regardless of empty (unlike the predecessor, which cleared on empty). They are not re-evaluated on BODY flits.
  - On pop&~empty&flit_type==TAIL: ports, deroute and busy clear at the next edge; return to IDLE.
  - The next HEADER is routable from the cycle after the clear (no back-to-back header in the same cycle).
- DROP:
  - discard = ~empty (combinational from state).
  - On pop&~empty&flit_type==TAIL: return to IDLE, busy=0.
  - route_err stays 1.
- cfg_we:
  - Honoured only in IDLE: all four config registers are written and route_err clears.
  - Ignored in ACTIVE/DROP.
  - Simultaneous cfg_we and HEADER in IDLE: the header is routed with the pre-write config; new values take effect next cycle.
- Reset mid-packet: immediate return to the reset state; the in-flight route is lost.
- dst_addr==cur_addr: Lport regardless of Cx.

Test Plan:
- COORD_W=2, cur=(1,1), Cx=4'hF, dst=(3,1) HEADER, then BODY, then TAIL with pop each cycle -> Eport=1 from cycle after header through TAIL pop; 0 next cycle; busy tracks the same.
- cur=(1,1), dst=(0,0), Rnw=1, Rwn=0 -> Nport only; with Rnw=0, Rwn=1 -> Wport only; with both set -> Nport (priority).
- cur=(1,1), dst=(1,3), Cs=0, dr=2'b01, Ce=1 -> Eport=1, deroute=1; same with Ce=0 -> ports 0, route_err=1, discard=1 while ~empty until TAIL pop, then IDLE.
- ACTIVE on Wport, empty=1 for 3 cycles between BODY flits -> Wport remains 1; cfg_we during ACTIVE leaves config unchanged.
- IDLE: cfg_we with cur_addr_in=(2,2) in the same cycle as HEADER dst=(2,2) from cur=(0,0) -> first packet routes E; next header dst=(2,2) -> Lport.
- rst=0 while in ACTIVE with Sport=1 -> all outputs 0 next edge; config reloads the *_rst values.
